// File: rtl/hilo_muldiv_unit.sv
// Iterative unsigned multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide, one operand bit per cycle.
module hilo_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;     // product upper half / partial remainder
   logic [WIDTH-1:0] x_q, x_d;         // multiplier / dividend-then-quotient
   logic [WIDTH-1:0] y_q, y_d;         // multiplicand / divisor
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic             last_iter;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state, datapath step and registered-output decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;

      mul_sum   = acc_q + {1'b0, (x_q[0] ? y_q : {WIDTH{1'b0}})};
      div_shift = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, y_q});
      div_diff  = div_shift[WIDTH-1:0] - y_q;
      last_iter = (cnt_q == CW'(WIDTH - 1));

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               cnt_d  = '0;
               dbz_d  = 1'b0;
               acc_d  = '0;
               x_d    = a;
               y_d    = b;
               busy_d = 1'b1;
               if (!op_div) begin
                  state_d = S_MUL;
               end else if (b == '0) begin
                  // Divide by zero completes immediately with a fixed result
                  state_d = S_FIN;
                  dbz_d   = 1'b1;
                  hi_d    = a;
                  lo_d    = '1;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_DIV;
               end
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end

         S_MUL: begin
            acc_d = {1'b0, mul_sum[WIDTH:1]};
            x_d   = {mul_sum[0], x_q[WIDTH-1:1]};
            if (cnt_q != CW'(WIDTH)) cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               state_d = S_FIN;
               hi_d    = mul_sum[WIDTH:1];
               lo_d    = {mul_sum[0], x_q[WIDTH-1:1]};
               done_d  = 1'b1;
            end
         end

         S_DIV: begin
            acc_d = {1'b0, (div_ge ? div_diff : div_shift[WIDTH-1:0])};
            x_d   = {x_q[WIDTH-2:0], div_ge};
            if (cnt_q != CW'(WIDTH)) cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               state_d = S_FIN;
               hi_d    = div_ge ? div_diff : div_shift[WIDTH-1:0];
               lo_d    = {x_q[WIDTH-2:0], div_ge};
               done_d  = 1'b1;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule
